lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store initiator between the RV32I core's memory stage and a single-port byte-masked SRAM block.
- The SRAM has one-cycle registered read latency, holds its read output while read enable is low, and uses per-byte write masks.
- The block accepts one core request at a time via a valid/ready handshake and drives the SRAM address, write data, bytemask and read/write enables.
- It aligns, sign- or zero-extends load data, returns it on a valid/ready response channel, and flags misaligned, illegal or out-of-range accesses.

Parameters:
- DEPTH, 512, SRAM depth in 32-bit words; byte address space is DEPTH*4.
- AW, $clog2(DEPTH*4), width of the SRAM byte address port (derived; do not override).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  core request valid.
- req_ready_o  output  1  block can accept a request; high only in IDLE.
- req_we_i  input  1  1 = store, 0 = load.
- req_funct3_i  input  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data, right-justified.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  core accepts response.
- rsp_rdata_o  output  32  extended load data; 0 for stores and errors.
- rsp_err_o  output  1  access faulted; no SRAM write occurred.
- mem_addr_o  output  AW  SRAM byte address; bits [1:0] always 0.
- mem_wr_data_o  output  32  lane-aligned write data.
- mem_bytemask_o  output  4  per-byte write enable.
- mem_write_en_o  output  1  SRAM write strobe.
- mem_read_en_o  output  1  SRAM read strobe.
- mem_rd_data_i  input  32  SRAM registered read data.

Behaviour:
- Reset (async, any time, including mid-access): state IDLE; any outstanding request dropped.
  - Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, all mem_* outputs 0.
- Accept: a request is accepted on an edge where req_valid_i && req_ready_o. addr, we, funct3 and wdata are registered.
- Check on accept; an error request goes IDLE->RESP with rsp_err_o=1 and no SRAM strobe. Error conditions:
  - illegal funct3 (loads 011/110/111; stores anything else but 000/001/010);
  - req_addr_i >= DEPTH*4;
  - misaligned access (half with addr[0]=1, word with addr[1:0]!=0) when the optional feature is off.
- States: IDLE, ISSUE, CAPTURE, RESP (plus ISSUE2 and CAPTURE2 with the optional feature).
- Load path: IDLE -> ISSUE -> CAPTURE -> RESP.
  - ISSUE: mem_read_en_o=1 for exactly one cycle.
  - CAPTURE: mem_rd_data_i is valid; byte lane selected by addr[1:0] (half lane by addr[1]); sign- or zero-extended per funct3; registered into rsp_rdata_o.
  - RESP is entered 3 cycles after accept.
- Store path: IDLE -> ISSUE -> RESP.
  - ISSUE: mem_write_en_o=1 for one cycle; mem_wr_data_o = wdata shifted left by 8*addr[1:0].
  - Bytemask: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111.
- mem_bytemask_o and mem_wr_data_o are 0 whenever mem_write_en_o=0.
- RESP: rsp_valid_o held high with stable data/err until rsp_ready_i; then IDLE. A new request can be accepted the cycle after the handshake.
- Arithmetic: mem_addr_o = {addr[AW-1:2],2'b00}; upper bits of req_addr_i are used only for the range check.

Optional Feature:
- LSU_MISALIGNED_EN defined: misaligned half/word accesses are split into two SRAM accesses instead of faulting.
  - First access: word at addr[AW-1:2]. Second access (ISSUE2/CAPTURE2): word index +1, wrapping modulo DEPTH.
  - Loads: the bytes from both words are merged before extension; latency 5 cycles accept->RESP.
  - Stores: two write cycles with complementary masks; the low bytes go to the first word. Example: SW at offset 3 -> 1000 then 0111.
- Undefined: misaligned accesses fault as described above.

Test Plan:
- SB addr 0x005, wdata 0x000000AB -> one write cycle: mem_addr_o 0x004, mask 0010, wr_data 0x0000AB00; rsp_valid after 2 cycles, err=0.
- Word 0x004 preloaded 0x80FF1234:
  - LB 0x007 -> rdata 0xFFFFFF80.
  - LBU 0x007 -> 0x00000080.
  - LH 0x006 -> 0xFFFF80FF.
  - LW 0x004 -> 0x80FF1234, rsp_valid 3 cycles after accept.
- rsp_ready_i held low 4 cycles in RESP -> rsp_valid_o/rsp_rdata_o stable, req_ready_o=0; accept on the cycle after the handshake.
- Errors, each -> err=1, no mem strobe, rdata 0:
  - LW 0x002 (macro off);
  - funct3 011 load;
  - address 0x800 with DEPTH=512.
- Assert rst_n_i during CAPTURE -> outputs reset immediately, no response is produced, and the next request completes normally.
- Macro on, word (DEPTH-1)=0x44332211, word 0=0x88776655:
  - LW at 4*DEPTH-2 -> two reads (word DEPTH-1, then word 0), rdata 0x66554433;
  - SW there -> masks 1100 then 0011.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// -----------------------------------------------------------------------------
// lsu_mem_initiator
//
// Purpose:
//   Load/store initiator that sits between the RV32I memory stage and a
//   single-port, byte-masked SRAM with one-cycle registered read latency.
//   One request is in flight at a time. The block lane-aligns store data,
//   generates byte masks, extracts and sign/zero-extends load data, and flags
//   illegal funct3, out-of-range and misaligned accesses.
//
// Optional feature (macro LSU_MISALIGNED_EN):
//   When defined, half/word accesses that straddle a word boundary are split
//   into two SRAM accesses (second word index wraps modulo DEPTH) instead of
//   faulting. When undefined, misaligned half/word accesses fault.
//
// Ports:
//   clk             clock, all state on rising edge
//   rst_n_i         asynchronous active-low reset
//   req_valid_i     core request valid
//   req_ready_o     request accepted when high (IDLE only)
//   req_we_i        1 = store, 0 = load
//   req_funct3_i    RV32I funct3 (access size / signedness)
//   req_addr_i      byte address
//   req_wdata_i     right-justified store data
//   rsp_valid_o     response valid, held until rsp_ready_i
//   rsp_ready_i     core accepts response
//   rsp_rdata_o     extended load data (0 for stores and errors)
//   rsp_err_o       access faulted, SRAM untouched
//   mem_addr_o      SRAM byte address, bits [1:0] always 0
//   mem_wr_data_o   lane-aligned write data (0 when not writing)
//   mem_bytemask_o  per-byte write enable (0 when not writing)
//   mem_write_en_o  SRAM write strobe
//   mem_read_en_o   SRAM read strobe
//   mem_rd_data_i   SRAM registered read data
// -----------------------------------------------------------------------------
module lsu_mem_initiator #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH * 4)
) (
    input  logic          clk,
    input  logic          rst_n_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [2:0]    req_funct3_i,
    input  logic [31:0]   req_addr_i,
    input  logic [31:0]   req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wr_data_o,
    output logic [3:0]    mem_bytemask_o,
    output logic          mem_write_en_o,
    output logic          mem_read_en_o,
    input  logic [31:0]   mem_rd_data_i
);

    localparam int          WW         = AW - 2;            // word index width
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP,
        S_ISSUE2,
        S_CAPTURE2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    // Sign/zero extension of a right-justified raw load value.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'b0, raw[7:0]};
            3'b101:  return {16'b0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Accept-time checks
    // ------------------------------------------------------------------
    logic f3_ok;
    logic range_ok;
    logic req_err;

    assign f3_ok = req_we_i ? (req_funct3_i inside {3'b000, 3'b001, 3'b010})
                            : (req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    // The full 32-bit address takes part here and nowhere else.
    assign range_ok = (req_addr_i < BYTE_LIMIT);

`ifdef LSU_MISALIGNED_EN
    assign req_err = !f3_ok || !range_ok;
`else
    logic misaligned;
    assign misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                        ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    assign req_err = !f3_ok || !range_ok || misaligned;
`endif

    // ------------------------------------------------------------------
    // Lane steering, shared by loads and stores
    // ------------------------------------------------------------------
    logic [1:0]    off_q;
    logic [WW-1:0] word_q;
    logic [5:0]    shamt;
    logic [3:0]    base_mask;
    logic [3:0]    lane_mask_lo;
    logic [31:0]   lane_data_lo;

    assign off_q  = addr_q[1:0];
    assign word_q = addr_q[AW-1:2];
    assign shamt  = {1'b0, off_q, 3'b000};

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
    end

    assign lane_mask_lo = base_mask << off_q;
    assign lane_data_lo = wdata_q << shamt;

`ifdef LSU_MISALIGNED_EN
    logic [WW-1:0] word_next;
    logic [3:0]    lane_mask_hi;
    logic [31:0]   lane_data_hi;
    logic          need_split;
    logic [31:0]   low_word_q, low_word_d;

    // Explicit wrap keeps non-power-of-two depths inside the array.
    assign word_next    = (word_q == WW'(DEPTH - 1)) ? '0 : word_q + 1'b1;
    // Bytes shifted past lane 3 belong to the next word; shifting by the
    // full width yields zero, so an aligned access never reaches word two.
    assign lane_mask_hi = base_mask >> (3'd4 - {1'b0, off_q});
    assign lane_data_hi = wdata_q >> (6'd32 - shamt);
    // Only accesses that actually cross a word boundary take two beats; a
    // half at offset 1 still lives entirely in one word.
    assign need_split   = |lane_mask_hi;
`endif

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only; all next
    // values are computed in the combinational block below.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef LSU_MISALIGNED_EN
            low_word_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef LSU_MISALIGNED_EN
            low_word_q <= low_word_d;
`endif
        end
    end

    // NOTE: every signal written here gets its hold value first so that no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef LSU_MISALIGNED_EN
        low_word_d = low_word_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i[AW-1:0];
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    wdata_d  = req_wdata_i;
                    rdata_d  = '0;
                    err_d    = req_err;
                    state_d  = req_err ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef LSU_MISALIGNED_EN
                if (we_q) state_d = need_split ? S_ISSUE2 : S_RESP;
                else      state_d = S_CAPTURE;
`else
                state_d = we_q ? S_RESP : S_CAPTURE;
`endif
            end
            S_CAPTURE: begin
`ifdef LSU_MISALIGNED_EN
                if (need_split) begin
                    low_word_d = mem_rd_data_i;
                    state_d    = S_ISSUE2;
                end else begin
                    rdata_d = load_extend(funct3_q, mem_rd_data_i >> shamt);
                    state_d = S_RESP;
                end
`else
                rdata_d = load_extend(funct3_q, mem_rd_data_i >> shamt);
                state_d = S_RESP;
`endif
            end
`ifdef LSU_MISALIGNED_EN
            S_ISSUE2: begin
                state_d = we_q ? S_RESP : S_CAPTURE2;
            end
            S_CAPTURE2: begin
                // Upper bytes of the first word join the low bytes of the
                // second before extension.
                rdata_d = load_extend(funct3_q, (low_word_q >> shamt) |
                                                (mem_rd_data_i << (6'd32 - shamt)));
                state_d = S_RESP;
            end
`endif
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state, so strobes are glitch-free
    // and mask/data stay zero outside write cycles.
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr_o     = '0;
        mem_wr_data_o  = '0;
        mem_bytemask_o = '0;
        mem_write_en_o = 1'b0;
        mem_read_en_o  = 1'b0;
        case (state_q)
            S_ISSUE: begin
                mem_addr_o = {word_q, 2'b00};
                if (we_q) begin
                    mem_write_en_o = 1'b1;
                    mem_bytemask_o = lane_mask_lo;
                    mem_wr_data_o  = lane_data_lo;
                end else begin
                    mem_read_en_o = 1'b1;
                end
            end
`ifdef LSU_MISALIGNED_EN
            S_ISSUE2: begin
                mem_addr_o = {word_next, 2'b00};
                if (we_q) begin
                    mem_write_en_o = 1'b1;
                    mem_bytemask_o = lane_mask_hi;
                    mem_wr_data_o  = lane_data_hi;
                end else begin
                    mem_read_en_o = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_initiator
//
// Directed bench for lsu_mem_initiator with a byte-masked SRAM model
// (one-cycle registered read, output held while read enable is low).
// Expected values are hand-computed constants. Stimulus is driven on the
// falling edge; outputs are sampled on the falling edge.
// The split-access checks are compiled in when LSU_MISALIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_lsu_mem_initiator;

    localparam int DEPTH = 512;
    localparam int AW    = $clog2(DEPTH * 4);

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [2:0]    req_funct3_i;
    logic [31:0]   req_addr_i;
    logic [31:0]   req_wdata_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wr_data_o;
    logic [3:0]    mem_bytemask_o;
    logic          mem_write_en_o;
    logic          mem_read_en_o;
    logic [31:0]   mem_rd_data_i;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n_i        (rst_n_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_funct3_i   (req_funct3_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .mem_bytemask_o (mem_bytemask_o),
        .mem_write_en_o (mem_write_en_o),
        .mem_read_en_o  (mem_read_en_o),
        .mem_rd_data_i  (mem_rd_data_i)
    );

    // ---------------------------------------------------------------- SRAM
    logic [31:0] sram [DEPTH];

    always @(posedge clk) begin
        if (mem_write_en_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_bytemask_o[b])
                    sram[mem_addr_o[AW-1:2]][8*b +: 8] <= mem_wr_data_o[8*b +: 8];
        end
        if (mem_read_en_o) mem_rd_data_i <= sram[mem_addr_o[AW-1:2]];
    end

    // ------------------------------------------------------- strobe logger
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [3:0]    mask;
        logic [31:0]   data;
    } strobe_t;

    strobe_t strobes [$];
    int      quiet_viol = 0;

    always @(negedge clk) begin
        if (mem_write_en_o || mem_read_en_o)
            strobes.push_back('{mem_write_en_o, mem_addr_o, mem_bytemask_o, mem_wr_data_o});
        if (!mem_write_en_o && (mem_bytemask_o != 4'b0 || mem_wr_data_o != 32'b0))
            quiet_viol++;
        if (mem_write_en_o && mem_read_en_o)
            quiet_viol++;
    end

    // ------------------------------------------------------------- checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_strobe(input string tag, input int idx, input logic we,
                                input logic [AW-1:0] addr, input logic [3:0] mask,
                                input logic [31:0] data);
        strobe_t s;
        if (idx < strobes.size()) begin
            s = strobes[idx];
            check(tag, 64'(s), 64'({we, addr, mask, data}));
        end else begin
            check({tag, "_missing"}, 64'(strobes.size()), 64'(idx + 1));
        end
    endtask

    // One complete request/response. Response is checked against exp_*;
    // rsp_ready_i is held low for 'hold' cycles after rsp_valid_o appears.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int hold, output int lat, output int base);
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check({tag, "_ready"}, 64'(req_ready_o), 64'd1);
        base         = strobes.size();
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            req_valid_i = 1'b0;
            lat++;
        end while (!rsp_valid_o && lat < 20);
        check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd1);
        if (!rsp_valid_o) return;
        check({tag, "_rdata"}, 64'(rsp_rdata_o), 64'(exp_rdata));
        check({tag, "_err"}, 64'(rsp_err_o), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'({rsp_valid_o, req_ready_o}), 64'({1'b1, 1'b0}));
            check({tag, "_hold_data"}, 64'({rsp_err_o, rsp_rdata_o}), 64'({exp_err, exp_rdata}));
        end
        rsp_ready_i = 1'b1;
        @(posedge clk);
    endtask

    // ------------------------------------------------------------- stimulus
    int lat;
    int base;
    int seen;

    initial begin
        rst_n_i      = 1'b0;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b000;
        req_addr_i   = 32'h0;
        req_wdata_i  = 32'h0;
        rsp_ready_i  = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready_valid", 64'({req_ready_o, rsp_valid_o}), 64'({1'b1, 1'b0}));
        check("rst_rsp", 64'({rsp_err_o, rsp_rdata_o}), 64'd0);
        check("rst_mem", 64'({mem_addr_o, mem_bytemask_o, mem_write_en_o, mem_read_en_o}), 64'd0);
        check("rst_mem_wdata", 64'(mem_wr_data_o), 64'd0);
        rst_n_i = 1'b1;

        // SB 0x005: one write, lane 1
        do_req("sb", 1'b1, 3'b000, 32'h005, 32'h0000_00AB, 32'h0, 1'b0, 0, lat, base);
        check("sb_lat", 64'(lat), 64'd2);
        check("sb_count", 64'(strobes.size() - base), 64'd1);
        check_strobe("sb_strobe", base, 1'b1, 11'h004, 4'b0010, 32'h0000_AB00);

        // SW 0x004 preloads 0x80FF1234
        do_req("sw", 1'b1, 3'b010, 32'h004, 32'h80FF_1234, 32'h0, 1'b0, 0, lat, base);
        check("sw_lat", 64'(lat), 64'd2);
        check_strobe("sw_strobe", base, 1'b1, 11'h004, 4'b1111, 32'h80FF_1234);

        // Loads from word 0x004
        do_req("lb", 1'b0, 3'b000, 32'h007, 32'h0, 32'hFFFF_FF80, 1'b0, 0, lat, base);
        check("lb_count", 64'(strobes.size() - base), 64'd1);
        check_strobe("lb_strobe", base, 1'b0, 11'h004, 4'b0000, 32'h0);
        do_req("lbu", 1'b0, 3'b100, 32'h007, 32'h0, 32'h0000_0080, 1'b0, 0, lat, base);
        do_req("lbu1", 1'b0, 3'b100, 32'h005, 32'h0, 32'h0000_0012, 1'b0, 0, lat, base);
        do_req("lh", 1'b0, 3'b001, 32'h006, 32'h0, 32'hFFFF_80FF, 1'b0, 0, lat, base);

        // LW with backpressure; next accept follows the handshake directly
        do_req("lw_hold", 1'b0, 3'b010, 32'h004, 32'h0, 32'h80FF_1234, 1'b0, 4, lat, base);
        check("lw_lat", 64'(lat), 64'd3);

        // SH upper half of word 0x008, then read it back both ways
        do_req("sh", 1'b1, 3'b001, 32'h00A, 32'h1234_BEEF, 32'h0, 1'b0, 0, lat, base);
        check_strobe("sh_strobe", base, 1'b1, 11'h008, 4'b1100, 32'hBEEF_0000);
        do_req("lhu", 1'b0, 3'b101, 32'h00A, 32'h0, 32'h0000_BEEF, 1'b0, 0, lat, base);
        do_req("lh_neg", 1'b0, 3'b001, 32'h00A, 32'h0, 32'hFFFF_BEEF, 1'b0, 0, lat, base);

        // Highest legal word
        do_req("sw_top", 1'b1, 3'b010, 32'h7FC, 32'h4433_2211, 32'h0, 1'b0, 0, lat, base);
        check_strobe("sw_top_strobe", base, 1'b1, 11'h7FC, 4'b1111, 32'h4433_2211);
        do_req("lw_top", 1'b0, 3'b010, 32'h7FC, 32'h0, 32'h4433_2211, 1'b0, 0, lat, base);

        // Faulting requests: no strobe, rdata 0, response next cycle
        do_req("err_f3_ld", 1'b0, 3'b011, 32'h004, 32'h0, 32'h0, 1'b1, 0, lat, base);
        check("err_f3_ld_count", 64'(strobes.size() - base), 64'd0);
        check("err_f3_ld_lat", 64'(lat), 64'd1);
        do_req("err_range", 1'b0, 3'b010, 32'h800, 32'h0, 32'h0, 1'b1, 0, lat, base);
        check("err_range_count", 64'(strobes.size() - base), 64'd0);
        do_req("err_f3_st", 1'b1, 3'b100, 32'h004, 32'hDEAD_BEEF, 32'h0, 1'b1, 0, lat, base);
        check("err_f3_st_count", 64'(strobes.size() - base), 64'd0);
        do_req("err_hi_addr", 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 1'b1, 0, lat, base);
        check("err_hi_addr_count", 64'(strobes.size() - base), 64'd0);
        do_req("lw_after_err", 1'b0, 3'b010, 32'h004, 32'h0, 32'h80FF_1234, 1'b0, 0, lat, base);

        // Reset in CAPTURE: outputs clear at once, no response follows
        @(negedge clk);
        rsp_ready_i  = 1'b0;
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h7FC;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        check("rc_issue_rd", 64'(mem_read_en_o), 64'd1);
        @(negedge clk);
        rst_n_i = 1'b0;
        #1;
        check("rc_ready_valid", 64'({req_ready_o, rsp_valid_o}), 64'({1'b1, 1'b0}));
        check("rc_rsp", 64'({rsp_err_o, rsp_rdata_o}), 64'd0);
        check("rc_mem", 64'({mem_addr_o, mem_bytemask_o, mem_write_en_o, mem_read_en_o}), 64'd0);
        @(negedge clk);
        rst_n_i = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid_o) seen++;
        end
        check("rc_no_rsp", 64'(seen), 64'd0);
        do_req("rc_next", 1'b0, 3'b010, 32'h004, 32'h0, 32'h80FF_1234, 1'b0, 0, lat, base);
        check("rc_next_lat", 64'(lat), 64'd3);

`ifdef LSU_MISALIGNED_EN
        // Word DEPTH-1 = 0x44332211 (written above), word 0 = 0x88776655
        do_req("sw_w0", 1'b1, 3'b010, 32'h000, 32'h8877_6655, 32'h0, 1'b0, 0, lat, base);
        do_req("lw_split", 1'b0, 3'b010, 32'h7FE, 32'h0, 32'h6655_4433, 1'b0, 0, lat, base);
        check("lw_split_lat", 64'(lat), 64'd5);
        check("lw_split_count", 64'(strobes.size() - base), 64'd2);
        check_strobe("lw_split_rd0", base, 1'b0, 11'h7FC, 4'b0000, 32'h0);
        check_strobe("lw_split_rd1", base + 1, 1'b0, 11'h000, 4'b0000, 32'h0);
        do_req("sw_split", 1'b1, 3'b010, 32'h7FE, 32'hDDCC_BBAA, 32'h0, 1'b0, 0, lat, base);
        check("sw_split_count", 64'(strobes.size() - base), 64'd2);
        check_strobe("sw_split_wr0", base, 1'b1, 11'h7FC, 4'b1100, 32'hBBAA_0000);
        check_strobe("sw_split_wr1", base + 1, 1'b1, 11'h000, 4'b0011, 32'h0000_DDCC);
        do_req("lw_top_after", 1'b0, 3'b010, 32'h7FC, 32'h0, 32'hBBAA_2211, 1'b0, 0, lat, base);
        do_req("lw_w0_after", 1'b0, 3'b010, 32'h000, 32'h0, 32'h8877_DDCC, 1'b0, 0, lat, base);
`else
        do_req("err_mis_lw", 1'b0, 3'b010, 32'h002, 32'h0, 32'h0, 1'b1, 0, lat, base);
        check("err_mis_lw_count", 64'(strobes.size() - base), 64'd0);
        do_req("err_mis_lh", 1'b0, 3'b001, 32'h7FF, 32'h0, 32'h0, 1'b1, 0, lat, base);
        check("err_mis_lh_count", 64'(strobes.size() - base), 64'd0);
        do_req("err_mis_sw", 1'b1, 3'b010, 32'h7FE, 32'h1111_1111, 32'h0, 1'b1, 0, lat, base);
        check("err_mis_sw_count", 64'(strobes.size() - base), 64'd0);
        do_req("lw_top_intact", 1'b0, 3'b010, 32'h7FC, 32'h0, 32'h4433_2211, 1'b0, 0, lat, base);
`endif

        @(negedge clk);
        rsp_ready_i = 1'b0;
        check("mask_data_quiet", 64'(quiet_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
